// File: rtl/gate_arb_pkg.sv
// Shared types and constants for the gate_arb_ctrl block.
package gate_arb_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } gate_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } arb_state_t;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/gate_arb_ctrl_alu.sv
// Registered bitwise unit (AND/OR/XOR/NAND); result updates only when load_i is high.
module gate_alu
  import gate_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  gate_op_t         op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             load_i,
  output logic [WIDTH-1:0] y_o
);

  logic [WIDTH-1:0] y_d, y_q;

  always_comb begin
    y_d = '0;
    unique case (op_i)
      OP_AND:  y_d = a_i & b_i;
      OP_OR:   y_d = a_i | b_i;
      OP_XOR:  y_d = a_i ^ b_i;
      OP_NAND: y_d = ~(a_i & b_i);
      default: y_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
    end else if (load_i) begin
      y_q <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/gate_arb_ctrl.sv
// Round-robin shared bitwise unit for NREQ requesters; IDLE -> EXEC -> RESP sequencing.
// Optional per-requester grant counters when GATE_ARB_STATS_EN is defined.
module gate_arb_ctrl
  import gate_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*2-1:0]     req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id
`ifdef GATE_ARB_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0] grant_cnt
`endif
);

  arb_state_t       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  gate_op_t         op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDW-1:0]   grant_idx, cand;
  logic             any_req;
  logic             alu_load;

  // Search downward so the candidate nearest ptr+1 is the last one written and wins.
  always_comb begin
    any_req   = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (req_valid[cand]) begin
        any_req   = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    req_ready = '0;
    alu_load  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          req_ready[grant_idx] = 1'b1;
          ptr_d   = grant_idx;
          id_d    = grant_idx;
          op_d    = gate_op_t'(req_op[2*int'(grant_idx) +: 2]);
          a_d     = req_a[WIDTH*int'(grant_idx) +: WIDTH];
          b_d     = req_b[WIDTH*int'(grant_idx) +: WIDTH];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_load = 1'b1;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      id_q    <= '0;
      op_q    <= OP_AND;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  gate_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .clk    (clk),
    .rst_n  (rst_n),
    .op_i   (op_q),
    .a_i    (a_q),
    .b_i    (b_q),
    .load_i (alu_load),
    .y_o    (rsp_data)
  );

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;

`ifdef GATE_ARB_STATS_EN
  logic [NREQ-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == S_IDLE) && any_req && (cnt_q[grant_idx] != '1)) begin
      cnt_d[grant_idx] = cnt_q[grant_idx] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule
